// File: rtl/tick_ctrl_pkg.sv
// rtl/tick_ctrl_pkg.sv - shared mode/position constants for tick_ctrl and the time datapath
package tick_ctrl_pkg;

    // Operating modes; the fourth encoding is unused and recovers to CLOCK
    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2
    } mode_e;

    // Which field the increment button edits
    localparam logic POS_SEC = 1'b0;
    localparam logic POS_MIN = 1'b1;

    // Bit positions of the push-buttons on i_sw
    localparam int SW_MODE  = 0;
    localparam int SW_POS   = 1;
    localparam int SW_INC   = 2;
    localparam int SW_ALARM = 3;

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_press.sv
// rtl/btn_press.sv - button synchronizer, sampled debounce, press pulse and optional auto-repeat
module btn_press
    import tick_ctrl_pkg::*;
#(
    parameter int HOLD_SMP = 100,
    parameter int RPT_SMP  = 20,
    parameter bit RPT_EN   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_n,
    input  logic smp_tick,
    output logic press
);

    localparam int CNT_MAX = (HOLD_SMP > RPT_SMP) ? HOLD_SMP : RPT_SMP;
    localparam int CW      = cnt_width(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_SMP);
    localparam logic [CW-1:0] RPT_LIM  = CW'(RPT_SMP);

    logic [1:0]    sync_q;
    logic [1:0]    hist_q;      // [0] = previous sample, [1] = the one before
    logic          armed_q;     // a genuine released sample has been seen since reset
    logic          held_q;      // button still down after a press, repeat timing active
    logic          rpt_q;       // initial hold delay elapsed, now in repeat cadence
    logic [CW-1:0] hold_cnt_q;
    logic          smp;
    logic [CW-1:0] cnt_inc;

    assign smp     = sync_q[1];
    assign cnt_inc = hold_cnt_q + 1'b1;

    // Two-flop synchronizer; resets to the released level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sw_n};
        end
    end

    // Sample history, press recognition (1,0,0) and hold/repeat timing
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q     <= 2'b11;
            armed_q    <= 1'b0;
            held_q     <= 1'b0;
            rpt_q      <= 1'b0;
            hold_cnt_q <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (smp_tick) begin
                hist_q <= {hist_q[0], smp};
                if (smp) begin
                    // Released: arm detection and abandon any hold in progress
                    armed_q    <= 1'b1;
                    held_q     <= 1'b0;
                    rpt_q      <= 1'b0;
                    hold_cnt_q <= '0;
                end else if (armed_q && hist_q == 2'b10) begin
                    press      <= 1'b1;
                    held_q     <= RPT_EN;
                    rpt_q      <= 1'b0;
                    hold_cnt_q <= '0;
                end else if (held_q) begin
                    if (!rpt_q && cnt_inc == HOLD_LIM) begin
                        press      <= 1'b1;
                        rpt_q      <= 1'b1;
                        hold_cnt_q <= '0;
                    end else if (rpt_q && cnt_inc == RPT_LIM) begin
                        press      <= 1'b1;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - clock/alarm mode control, button handling and 1 Hz count enables
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int SAMPLE_DIV = 500000,
    parameter int HOLD_SMP   = 100,
    parameter int RPT_SMP    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_sw,
    input  logic       i_max_hit_sec,
    output logic [1:0] o_mode,
    output logic       o_position,
    output logic       o_alarm_en,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_alarm_sec_inc,
    output logic       o_alarm_min_inc,
    output logic       o_tick_1hz
);

    localparam int PW = cnt_width(CLK_HZ);
    localparam int SW = cnt_width(SAMPLE_DIV);
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SMP_TC = SW'(SAMPLE_DIV - 1);

    logic [SW-1:0] smp_cnt_q;
    logic          smp_tick;
    logic [PW-1:0] pre_cnt_q;
    logic          pre_tc;
    logic [3:0]    press;
    mode_e         mode_q;

    logic mode_press;
    logic pos_press;
    logic inc_press;
    logic alarm_press;
    logic enter_setup;
    logic hold_pre;
    logic tick_now;

    assign smp_tick    = (smp_cnt_q == SMP_TC);
    assign pre_tc      = (pre_cnt_q == PRE_TC);
    assign mode_press  = press[SW_MODE];
    assign pos_press   = press[SW_POS];
    // A mode change takes priority over an increment arriving the same cycle
    assign inc_press   = press[SW_INC] & ~mode_press;
    assign alarm_press = press[SW_ALARM];
    // Hold the prescaler from the very cycle SETUP is entered so no tick leaks in
    assign enter_setup = mode_press && (mode_q == MODE_CLOCK);
    assign hold_pre    = (mode_q == MODE_SETUP) || enter_setup;
    assign tick_now    = pre_tc && !hold_pre;
    assign o_mode      = mode_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_press #(
            .HOLD_SMP (HOLD_SMP),
            .RPT_SMP  (RPT_SMP),
            .RPT_EN   (gi == SW_INC)
        ) u_btn (
            .clk      (clk),
            .rst      (rst),
            .sw_n     (i_sw[gi]),
            .smp_tick (smp_tick),
            .press    (press[gi])
        );
    end

    // Free-running divider producing the shared switch-sample strobe
    always_ff @(posedge clk) begin
        if (rst || smp_tick) begin
            smp_cnt_q <= '0;
        end else begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
        end
    end

    // 1 Hz prescaler, parked at 0 in SETUP so ALARM restarts a full period
    always_ff @(posedge clk) begin
        if (rst || hold_pre || pre_tc) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
        end
    end

    // Mode FSM: CLOCK -> SETUP -> ALARM -> CLOCK on each mode press
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_CLOCK;
        end else begin
            case (mode_q)
                MODE_CLOCK: if (mode_press) mode_q <= MODE_SETUP;
                MODE_SETUP: if (mode_press) mode_q <= MODE_ALARM;
                MODE_ALARM: if (mode_press) mode_q <= MODE_CLOCK;
                default:    mode_q <= MODE_CLOCK;
            endcase
        end
    end

    // Position and alarm-enable toggles, independent of mode
    always_ff @(posedge clk) begin
        if (rst) begin
            o_position <= POS_SEC;
            o_alarm_en <= 1'b0;
        end else begin
            if (pos_press) begin
                o_position <= ~o_position;
            end
            if (alarm_press) begin
                o_alarm_en <= ~o_alarm_en;
            end
        end
    end

    // Registered count-enable routing; the increment uses the pre-toggle position
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tick_1hz      <= 1'b0;
            o_sec_inc       <= 1'b0;
            o_min_inc       <= 1'b0;
            o_alarm_sec_inc <= 1'b0;
            o_alarm_min_inc <= 1'b0;
        end else begin
            o_tick_1hz      <= tick_now;
            o_alarm_sec_inc <= 1'b0;
            o_alarm_min_inc <= 1'b0;
            case (mode_q)
                MODE_SETUP: begin
                    o_sec_inc <= inc_press && (o_position == POS_SEC);
                    o_min_inc <= inc_press && (o_position == POS_MIN);
                end
                MODE_ALARM: begin
                    o_sec_inc       <= tick_now;
                    o_min_inc       <= i_max_hit_sec;
                    o_alarm_sec_inc <= inc_press && (o_position == POS_SEC);
                    o_alarm_min_inc <= inc_press && (o_position == POS_MIN);
                end
                default: begin
                    o_sec_inc <= tick_now;
                    o_min_inc <= i_max_hit_sec;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - scoreboard bench for tick_ctrl with directed button vectors
module tb_tick_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i_sw = 4'hF;
    logic       i_max_hit_sec = 1'b0;
    logic [1:0] o_mode;
    logic       o_position;
    logic       o_alarm_en;
    logic       o_sec_inc;
    logic       o_min_inc;
    logic       o_alarm_sec_inc;
    logic       o_alarm_min_inc;
    logic       o_tick_1hz;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] last_state = 4'h0;

    tick_ctrl #(
        .CLK_HZ     (100),
        .SAMPLE_DIV (4),
        .HOLD_SMP   (5),
        .RPT_SMP    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_sw            (i_sw),
        .i_max_hit_sec   (i_max_hit_sec),
        .o_mode          (o_mode),
        .o_position      (o_position),
        .o_alarm_en      (o_alarm_en),
        .o_sec_inc       (o_sec_inc),
        .o_min_inc       (o_min_inc),
        .o_alarm_sec_inc (o_alarm_sec_inc),
        .o_alarm_min_inc (o_alarm_min_inc),
        .o_tick_1hz      (o_tick_1hz)
    );

    always #5 clk = ~clk;

    // Edges since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // {mode, pos, alarm_en, sec, min, asec, amin, tick}
    function automatic logic [8:0] ev(input int m, input int p, input int a, input int s,
                                      input int mi, input int ai, input int am, input int t);
        return {m[1:0], p[0], a[0], s[0], mi[0], ai[0], am[0], t[0]};
    endfunction

    function automatic logic [8:0] out_vec();
        return {o_mode, o_position, o_alarm_en, o_sec_inc, o_min_inc,
                o_alarm_sec_inc, o_alarm_min_inc, o_tick_1hz};
    endfunction

    // Monitor: any pulse or state change is an event matched against the queue head
    always @(negedge clk) begin
        logic [8:0] vec;
        exp_t       e;
        vec = out_vec();
        if (rst || cyc == 0) begin
            last_state = 4'h0;
        end else if (vec[4:0] != 5'd0 || vec[8:5] != last_state) begin
            last_state = vec[8:5];
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d got=%b required=no event", cyc, vec);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec != vec) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d vec=%b required cyc=%0d vec=%b",
                             cyc, vec, e.cyc, e.vec);
                end
            end
        end
    end

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [8:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] mask, input int start, input int len);
        at(start);
        i_sw = i_sw & ~mask;
        at(start + len);
        i_sw = i_sw | mask;
    endtask

    task automatic pulse_max(input int n);
        at(n);
        i_max_hit_sec = 1'b1;
        at(n + 1);
        i_max_hit_sec = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: missing events=%0d required=0, next expected cyc=%0d",
                     name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() != 9'd0) begin
            errors++;
            $display("FAIL reset_state: got=%b required=%b", out_vec(), 9'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        // Free-running CLOCK mode: ticks every 100 cycles, minute carry follows input
        do_reset();
        push(100, ev(0, 0, 0, 1, 0, 0, 0, 1));
        push(151, ev(0, 0, 0, 0, 1, 0, 0, 0));
        push(200, ev(0, 0, 0, 1, 0, 0, 0, 1));
        pulse_max(150);
        at(250);
        check_drained("clock_mode");

        // Enter SETUP once, no ticks, carry ignored
        do_reset();
        push(13, ev(1, 0, 0, 0, 0, 0, 0, 0));
        hold(4'b0001, 4, 12);
        pulse_max(150);

        // Position MIN, then held increment with auto-repeat
        push(169, ev(1, 1, 0, 0, 0, 0, 0, 0));
        hold(4'b0010, 160, 12);
        push(209, ev(1, 1, 0, 0, 1, 0, 0, 0));
        push(229, ev(1, 1, 0, 0, 1, 0, 0, 0));
        push(237, ev(1, 1, 0, 0, 1, 0, 0, 0));
        push(245, ev(1, 1, 0, 0, 1, 0, 0, 0));
        push(253, ev(1, 1, 0, 0, 1, 0, 0, 0));
        push(261, ev(1, 1, 0, 0, 1, 0, 0, 0));
        hold(4'b0100, 200, 60);

        // Single-sample glitches on increment and mode produce nothing
        hold(4'b0100, 280, 4);
        hold(4'b0001, 300, 4);

        // ALARM: prescaler restarts, alarm increments follow position
        push(329, ev(2, 1, 0, 0, 0, 0, 0, 0));
        hold(4'b0001, 320, 12);
        push(349, ev(2, 1, 0, 0, 0, 0, 1, 0));
        hold(4'b0100, 340, 12);
        push(369, ev(2, 0, 0, 0, 0, 0, 0, 0));
        hold(4'b0010, 360, 12);
        push(389, ev(2, 0, 0, 0, 0, 1, 0, 0));
        hold(4'b0100, 380, 12);

        // Mode and increment together: mode wins, then tick 100 cycles after ALARM entry
        push(409, ev(0, 0, 0, 0, 0, 0, 0, 0));
        push(429, ev(0, 0, 0, 1, 0, 0, 0, 1));
        hold(4'b0101, 400, 12);

        // Alarm enable toggles, then reset during a held press
        push(449, ev(0, 0, 1, 0, 0, 0, 0, 0));
        hold(4'b1000, 440, 12);
        push(469, ev(0, 0, 0, 0, 0, 0, 0, 0));
        hold(4'b1000, 460, 12);
        push(489, ev(0, 0, 1, 0, 0, 0, 0, 0));
        at(480);
        i_sw[3] = 1'b0;
        at(500);
        check_drained("setup_alarm");
        do_reset();

        // Still held after reset: no toggle until released and pressed again
        at(40);
        i_sw[3] = 1'b1;
        push(69, ev(0, 0, 1, 0, 0, 0, 0, 0));
        hold(4'b1000, 60, 12);
        at(90);
        check_drained("reset_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency; sets the 1 Hz tick period.
REQ-002 Parameter SAMPLE_DIV, default 500000: clocks per switch-sample tick (100 Hz at default).
REQ-003 Parameter HOLD_SMP, default 100: samples held before auto-repeat starts.
REQ-004 Parameter RPT_SMP, default 20: samples between auto-repeat pulses.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port i_sw, input, 4 bits: raw push-buttons, active-low (0 = pressed), asynchronous; bit0 mode, bit1 position, bit2 increment, bit3 alarm enable.
REQ-008 Port i_max_hit_sec, input, 1 bit: one-cycle pulse when the seconds counter wraps 59->0.
REQ-009 Port o_mode, output, 2 bits: 0 CLOCK, 1 SETUP, 2 ALARM.
REQ-010 Port o_position, output, 1 bit: 0 SEC, 1 MIN.
REQ-011 Port o_alarm_en, output, 1 bit: alarm armed.
REQ-012 Ports o_sec_inc, o_min_inc, o_alarm_sec_inc, o_alarm_min_inc, outputs, 1 bit each: one-cycle count-enable pulses, never clocks.
REQ-013 Port o_tick_1hz, output, 1 bit: one-cycle pulse every CLK_HZ cycles.

Function
REQ-014 Each i_sw bit SHALL pass a 2-flop synchronizer, then be sampled on each sample tick (one-cycle pulse every SAMPLE_DIV cycles).
REQ-015 A press SHALL be recognised when two consecutive samples read 0 after a sample that read 1, and SHALL yield exactly one one-cycle press pulse on the cycle after the second 0 sample.
REQ-016 While bit2 stays pressed, after HOLD_SMP samples from the press, a further increment press pulse SHALL be produced every RPT_SMP samples until release.
REQ-017 Mode FSM: CLOCK->SETUP->ALARM->CLOCK on each bit0 press; value 3 is unreachable and SHALL recover to CLOCK on the next cycle.
REQ-018 A bit1 press SHALL toggle o_position; position is retained across mode changes.
REQ-019 A bit3 press SHALL toggle o_alarm_en in any mode.
REQ-020 The 1 Hz prescaler SHALL count 0..CLK_HZ-1; o_tick_1hz pulses at terminal count.
REQ-021 CLOCK mode: o_sec_inc = o_tick_1hz; o_min_inc = i_max_hit_sec; alarm increments are 0.
REQ-022 SETUP mode: the prescaler is held at 0 and o_tick_1hz is 0; an increment press SHALL pulse o_sec_inc (position SEC) or o_min_inc (position MIN) for one cycle; i_max_hit_sec is ignored.
REQ-023 ALARM mode: timekeeping as in CLOCK mode; an increment press SHALL pulse o_alarm_sec_inc or o_alarm_min_inc per position.
REQ-024 On SETUP->ALARM exit, the prescaler restarts from 0, so the first tick occurs CLK_HZ cycles after the mode change.
REQ-025 Mode and increment presses in the same cycle: the mode change SHALL win and the increment SHALL be dropped.
REQ-026 Position and increment presses in the same cycle: the increment SHALL use the old position.
REQ-027 In SETUP with position SEC, an increment press SHALL NOT generate o_min_inc on a seconds wrap.
REQ-028 All outputs SHALL be registered; press-to-output latency is 1 cycle after press detection.

Reset
REQ-029 With rst high at a clk edge, the block SHALL set: o_mode=0, o_position=0, o_alarm_en=0, all inc pulses=0, o_tick_1hz=0, prescaler=0, sample divider=0, hold counters=0, sample history=all 1 (released).
REQ-030 Reset asserted mid-press or mid-repeat SHALL discard the press; a button still held at reset release SHALL NOT generate a press until it is released and pressed again.

Structure
REQ-031 A shared package SHALL hold the MODE_CLOCK/SETUP/ALARM and POS_SEC/MIN constants used by tick_ctrl and the minute/second datapath.
REQ-032 One sub-module, btn_press (synchronizer, sample history, press pulse, optional auto-repeat), SHALL be instantiated four times; auto-repeat is enabled only for bit2.

Verification (CLK_HZ=100, SAMPLE_DIV=4, HOLD_SMP=5, RPT_SMP=2)
REQ-033 Bench: release rst, CLOCK mode, run 250 cycles -> o_sec_inc pulses at cycles 100 and 200 only; an injected i_max_hit_sec pulse -> o_min_inc pulse 1 cycle later.
REQ-034 Bench: bit0 pressed for 12 cycles -> o_mode 0->1 exactly once; prescaler stays 0 and no o_sec_inc while in SETUP.
REQ-035 Bench: SETUP, position MIN, bit2 held 60 cycles -> 1 initial o_min_inc, first repeat 20 cycles after the press, then one every 8 cycles; o_sec_inc stays 0.
REQ-036 Bench: ALARM, bit0 and bit2 detected in the same cycle -> o_mode=0, no alarm increment pulse.
REQ-037 Bench: bit3 pressed twice -> o_alarm_en 0->1->0; rst asserted during a bit3 hold -> o_alarm_en=0, and no toggle until re-press.
REQ-038 Bench: bit0/bit2 glitch of 1 sample -> no press pulse.
